// File: rtl/addroundkey_col_seq.sv
`timescale 1ns/1ps
// Streams a 128-bit block through a 32-bit AddRoundKey XOR stage one column per cycle and reassembles it.
// Latency 4 cycles accept-to-outValid; result holds in DONE until outReady, new block accepted on the same edge.
module addroundkey_col_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inBlock,
    output logic [31:0]  colData,
    output logic [1:0]   colIdx,
    input  logic [31:0]  colResult,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outBlock
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_idx;
    logic [127:0]  r_stateReg;
    logic [127:0]  r_outBlock;
    logic          w_accept;
    logic [31:0]   w_col;

    assign w_accept = inValid && inReady;
    assign outBlock = r_outBlock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_RUN;
            S_RUN:  if (r_idx == 2'd3) w_next = S_DONE;
            S_DONE: begin
                if (outReady) w_next = inValid ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Column 0 is the most significant word of the block.
    always_comb begin
        w_col = 32'd0;
        unique case (r_idx)
            2'd0: w_col = r_stateReg[127:96];
            2'd1: w_col = r_stateReg[95:64];
            2'd2: w_col = r_stateReg[63:32];
            2'd3: w_col = r_stateReg[31:0];
            default: w_col = 32'd0;
        endcase
    end

    always_comb begin
        inReady  = 1'b0;
        outValid = 1'b0;
        colData  = 32'd0;
        colIdx   = 2'd0;
        unique case (r_state)
            S_IDLE: inReady = 1'b1;
            S_RUN: begin
                colData = w_col;
                colIdx  = r_idx;
            end
            S_DONE: begin
                outValid = 1'b1;
                inReady  = outReady;
            end
            default: inReady = 1'b0;
        endcase
    end

    // Unwritten result columns keep the previous block; only meaningful once outValid is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= 2'd0;
            r_stateReg <= 128'd0;
            r_outBlock <= 128'd0;
        end else if (w_accept) begin
            r_stateReg <= inBlock;
            r_idx      <= 2'd0;
        end else if (r_state == S_RUN) begin
            unique case (r_idx)
                2'd0: r_outBlock[127:96] <= colResult;
                2'd1: r_outBlock[95:64]  <= colResult;
                2'd2: r_outBlock[63:32]  <= colResult;
                2'd3: r_outBlock[31:0]   <= colResult;
                default: r_outBlock <= r_outBlock;
            endcase
            r_idx <= r_idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_addroundkey_col_seq.sv
`timescale 1ns/1ps
// Scoreboard bench: driver pushes block^key at accept; negedge monitor checks column stream, latency and results.
module tb_addroundkey_col_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inValid = 1'b0;
    logic         outReady = 1'b0;
    logic [127:0] inBlock = '0;
    logic         inReady;
    logic         outValid;
    logic [31:0]  colData;
    logic [1:0]   colIdx;
    logic [31:0]  colResult;
    logic [127:0] outBlock;
    logic [127:0] key = '0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [127:0] exp_q[$];
    int           acc_q[$];
    int           run_start = -100;
    logic [127:0] run_blk = '0;
    int           last_acc = 0;
    bit           rand_ordy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    addroundkey_col_seq dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady), .inBlock(inBlock),
        .colData(colData), .colIdx(colIdx), .colResult(colResult),
        .outValid(outValid), .outReady(outReady), .outBlock(outBlock)
    );

    function automatic logic [31:0] col(input logic [127:0] b, input int k);
        logic [127:0] t;
        t = b >> (96 - 32 * k);
        return t[31:0];
    endfunction

    // XOR stage: column idx 0 uses key[127:96]
    assign colResult = colData ^ col(key, int'(colIdx));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Call shortly after a posedge; returns just after the accepting edge with inValid still high.
    task automatic send(input logic [127:0] blk, input logic [127:0] k);
        int n;
        n = 0;
        inBlock = blk;
        inValid = 1'b1;
        @(negedge clk);
        while (!inReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) begin
            timeout_fail("accept");
            inValid = 1'b0;
            return;
        end
        key = k;
        exp_q.push_back(blk ^ k);
        acc_q.push_back(cyc + 1);
        run_start = cyc + 1;
        run_blk   = blk;
        last_acc  = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
        @(posedge clk);
        #1;
    endtask

    // Monitor
    logic         prev_vld = 1'b0;
    logic         prev_rdy = 1'b0;
    logic [127:0] prev_blk = '0;

    always @(negedge clk) begin : monitor
        int k;
        int a;
        if (!rst_n) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            k = cyc - run_start;
            if (k >= 0 && k <= 3) begin
                chk("colIdx", colIdx, k);
                chk("colData", colData, col(run_blk, k));
                chk("outValid_in_run", outValid, 0);
            end else begin
                chk("colIdx_idle", colIdx, 0);
                chk("colData_idle", colData, 0);
            end
            if (prev_vld && !prev_rdy) begin
                chk("hold_outValid", outValid, 1);
                chk("hold_outBlock", outBlock, prev_blk);
            end
            if (outValid && (!prev_vld || prev_rdy)) begin
                if (acc_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_outValid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    a = acc_q.pop_front();
                    chk("latency", cyc - a, 4);
                end
            end
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_result: got %0h expected none", outBlock);
                end else begin
                    chk("outBlock", outBlock, exp_q.pop_front());
                end
            end
            prev_vld = outValid;
            prev_rdy = outReady;
            prev_blk = outBlock;
        end
    end

    always @(posedge clk) begin
        if (rand_ordy) begin
            #1 outReady = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_outValid"}, outValid, 0);
        chk({nm, "_inReady"}, inReady, 1);
        chk({nm, "_colData"}, colData, 0);
        chk({nm, "_colIdx"}, colIdx, 0);
        chk({nm, "_outBlock"}, outBlock, 0);
    endtask

    initial begin : main
        int a0;
        int n;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic known-answer
        outReady = 1'b1;
        send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
        inValid = 1'b0;
        wait_drain();
        chk("basic_kat", outBlock, 128'h00102030405060708090a0b0c0d0e0f0);

        // Identity with zero key
        send(128'hdeadbeef_01234567_89abcdef_cafef00d, 128'h0);
        inValid = 1'b0;
        wait_drain();
        chk("identity", outBlock, 128'hdeadbeef_01234567_89abcdef_cafef00d);

        // Back-pressure in DONE with next block pending
        outReady = 1'b0;
        send(128'h0f0e0d0c0b0a09080706050403020100, 128'h55aa55aa_0f0f0f0f_12345678_9abcdef0);
        inBlock = 128'h11111111_22222222_33333333_44444444;
        n = 0;
        @(negedge clk);
        while (!outValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!outValid) timeout_fail("bp_outValid");
        repeat (3) begin
            chk("bp_inReady", inReady, 0);
            chk("bp_outValid", outValid, 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 outReady = 1'b1;
        send(128'h11111111_22222222_33333333_44444444, 128'hffffffff_00000000_ffffffff_00000000);
        inValid = 1'b0;
        wait_drain();

        // Back-to-back
        send(128'h0123456789abcdef0123456789abcdef, 128'h1);
        a0 = last_acc;
        send(128'hfedcba9876543210fedcba9876543210, 128'h2);
        chk("b2b_gap1", last_acc - a0, 5);
        a0 = last_acc;
        send(128'h00000000ffffffff00000000ffffffff, 128'h3);
        chk("b2b_gap2", last_acc - a0, 5);
        inValid = 1'b0;
        wait_drain();

        // inValid pulse during RUN is ignored
        send(128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c, 128'h13579bdf_2468ace0_deadbeef_feedface);
        inValid = 1'b0;
        @(posedge clk);
        #1;
        inValid = 1'b1;
        inBlock = 128'hbbbbbbbb_bbbbbbbb_bbbbbbbb_bbbbbbbb;
        @(negedge clk);
        chk("run_inReady", inReady, 0);
        @(posedge clk);
        #1 inValid = 1'b0;
        wait_drain();

        // Asynchronous reset mid-RUN at colIdx 2
        send(128'hcccccccc_dddddddd_eeeeeeee_ffffffff, 128'h01010101_02020202_03030303_04040404);
        inValid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        exp_q.delete();
        acc_q.delete();
        run_start = -100;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_stale_outValid", outValid, 0);
        end
        @(posedge clk);
        #1;
        send(128'h98765432_10fedcba_13572468_abcdef01, 128'h0badc0de_0badc0de_0badc0de_0badc0de);
        inValid = 1'b0;
        wait_drain();

        // Randomized blocks, keys, gaps and downstream stalls
        rand_ordy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            inValid = 1'b0;
        end
        rand_ordy = 1'b0;
        @(posedge clk);
        #2 outReady = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

endmodule
